// File: rtl/ft_de_btb.sv
// ft_de_btb: fetch-to-decode pipeline register plus a small fully associative
// branch target buffer with a post-reset warm-up window that gates hit reporting.
module ft_de_btb #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BTB_DEPTH = 4,
    parameter int unsigned WARMUP    = 10
) (
    input  logic            clk,
    input  logic            cpurst_n,
    input  logic [XLEN-1:0] fetch_pc,
    input  logic [31:0]     fetch_instr,
    input  logic            fetch_rv16,
    input  logic            fetch_predict_taken,
    input  logic            fetch_valid,
    input  logic            stall,
    input  logic            flush,
    output logic [XLEN-1:0] de_pc,
    output logic [31:0]     de_instr,
    output logic            de_rv16,
    output logic            de_predict_taken,
    output logic            de_valid,
    input  logic            upd_en,
    input  logic [XLEN-1:0] upd_pc,
    input  logic [XLEN-1:0] upd_target,
    input  logic            btb_inval,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            btb_hit,
    output logic [XLEN-1:0] btb_target,
    output logic            btb_ready
);

    localparam int unsigned   IW       = (BTB_DEPTH > 1) ? $clog2(BTB_DEPTH) : 1;
    localparam logic [7:0]    WARM_CNT = 8'(WARMUP);
    localparam logic [IW-1:0] LAST_IDX = IW'(BTB_DEPTH - 1);

    // Pipeline register state
    logic [XLEN-1:0]      r_de_pc;
    logic [31:0]          r_de_instr;
    logic                 r_de_rv16;
    logic                 r_de_predict_taken;
    logic                 r_de_valid;

    // BTB state
    logic [BTB_DEPTH-1:0] r_valid;
    logic [XLEN-1:0]      r_tag    [BTB_DEPTH];
    logic [XLEN-1:0]      r_target [BTB_DEPTH];
    logic [IW-1:0]        r_ptr;
    logic [7:0]           r_warm;

    // Combinational helpers
    logic                 w_look_hit;
    logic [XLEN-1:0]      w_look_target;
    logic                 w_upd_hit;
    logic [IW-1:0]        w_upd_idx;
    logic                 w_free_any;
    logic [IW-1:0]        w_free_idx;
    logic [IW-1:0]        w_alloc_idx;
    logic                 w_ready;

    // Decode pipeline register: stall holds everything, flush squashes payload but keeps PC
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            r_de_pc            <= '0;
            r_de_instr         <= '0;
            r_de_rv16          <= 1'b0;
            r_de_predict_taken <= 1'b0;
            r_de_valid         <= 1'b0;
        end else if (!stall) begin
            r_de_pc <= fetch_pc;
            if (flush) begin
                r_de_instr         <= '0;
                r_de_rv16          <= 1'b0;
                r_de_predict_taken <= 1'b0;
                r_de_valid         <= 1'b0;
            end else begin
                r_de_instr         <= fetch_instr;
                r_de_rv16          <= fetch_rv16;
                r_de_predict_taken <= fetch_predict_taken;
                r_de_valid         <= fetch_valid;
            end
        end
    end

    assign de_pc            = r_de_pc;
    assign de_instr         = r_de_instr;
    assign de_rv16          = r_de_rv16;
    assign de_predict_taken = r_de_predict_taken;
    assign de_valid         = r_de_valid;

    // Lookup: full-tag compare of lookup_pc against every valid entry
    always_comb begin
        w_look_hit    = 1'b0;
        w_look_target = '0;
        for (int unsigned i = 0; i < BTB_DEPTH; i++) begin
            if (r_valid[i] && (r_tag[i] == lookup_pc)) begin
                w_look_hit    = 1'b1;
                w_look_target = r_target[i];
            end
        end
    end

    // Update slot selection: existing match, else lowest free entry, else replacement pointer
    always_comb begin
        w_upd_hit  = 1'b0;
        w_upd_idx  = '0;
        w_free_any = 1'b0;
        w_free_idx = '0;
        for (int unsigned i = 0; i < BTB_DEPTH; i++) begin
            if (r_valid[i] && (r_tag[i] == upd_pc)) begin
                w_upd_hit = 1'b1;
                w_upd_idx = IW'(i);
            end
            if (!r_valid[i] && !w_free_any) begin
                w_free_any = 1'b1;
                w_free_idx = IW'(i);
            end
        end
    end

    assign w_alloc_idx = w_upd_hit ? w_upd_idx : (w_free_any ? w_free_idx : r_ptr);

    // BTB storage: invalidate wins over update; pointer only advances on a full-table eviction
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            r_valid <= '0;
            r_ptr   <= '0;
            for (int unsigned i = 0; i < BTB_DEPTH; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
            end
        end else if (btb_inval) begin
            r_valid <= '0;
            r_ptr   <= '0;
        end else if (upd_en) begin
            // On a tag match valid/tag are rewritten with identical values, so only the target changes
            r_valid[w_alloc_idx]  <= 1'b1;
            r_tag[w_alloc_idx]    <= upd_pc;
            r_target[w_alloc_idx] <= upd_target;
            if (!w_upd_hit && !w_free_any) begin
                r_ptr <= (r_ptr == LAST_IDX) ? '0 : r_ptr + 1'b1;
            end
        end
    end

    // Warm-up counter: counts cycles since reset release, saturating at WARMUP
    always_ff @(posedge clk or negedge cpurst_n) begin
        if (!cpurst_n) begin
            r_warm <= '0;
        end else if (r_warm != WARM_CNT) begin
            r_warm <= r_warm + 8'd1;
        end
    end

    assign w_ready    = (r_warm == WARM_CNT);
    assign btb_ready  = w_ready;
    assign btb_hit    = w_ready && w_look_hit;
    assign btb_target = (w_ready && w_look_hit) ? w_look_target : '0;

endmodule

// File: doc/ft_de_btb.md
FT_DE_BTB -- requirements
Module: ft_de_btb

Interface
REQ-001 Parameter XLEN, 32, address/PC width.
REQ-002 Parameter BTB_DEPTH, 4, BTB entry count; power of two, 2..16.
REQ-003 Parameter WARMUP, 10, cycles after reset release before BTB hits are reported; 1..255.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 cpurst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 fetch_pc  in  XLEN  PC of fetched instruction.
REQ-007 fetch_instr  in  32  fetched instruction (rv16 in bits [15:0]).
REQ-008 fetch_rv16  in  1  fetched instruction is compressed.
REQ-009 fetch_predict_taken  in  1  fetch predicted taken.
REQ-010 fetch_valid  in  1  fetch outputs hold a real instruction.
REQ-011 stall  in  1  decode-side stall (any downstream stall ORed).
REQ-012 flush  in  1  pipeline flush or branch mispredict.
REQ-013 de_pc  out  XLEN  registered PC to decode.
REQ-014 de_instr  out  32  registered instruction; 0 = NOP.
REQ-015 de_rv16, de_predict_taken, de_valid  out  1 each  registered qualifiers.
REQ-016 upd_en  in  1  decode resolved a taken branch; write BTB.
REQ-017 upd_pc  in  XLEN  branch PC to record.
REQ-018 upd_target  in  XLEN  branch target to record.
REQ-019 btb_inval  in  1  invalidate all BTB entries.
REQ-020 lookup_pc  in  XLEN  PC to look up.
REQ-021 btb_hit  out  1  lookup_pc matches a valid entry and btb_ready.
REQ-022 btb_target  out  XLEN  target of matching entry; 0 when btb_hit=0.
REQ-023 btb_ready  out  1  warm-up complete.

Function
REQ-024 Pipeline register: stall=1 -> all de_* hold; flush ignored that cycle (upstream holds flush until unstalled).
REQ-025 stall=0, flush=1 -> de_instr=0, de_valid=0, de_rv16=0, de_predict_taken=0; de_pc still loads fetch_pc.
REQ-026 stall=0, flush=0 -> de_* load fetch_* next edge; de_valid loads fetch_valid; latency 1 cycle.
REQ-027 BTB entry = valid bit, XLEN-bit full tag, XLEN-bit target; no partial tag matching.
REQ-028 Lookup combinational from lookup_pc and current entries; same-cycle update not visible until next cycle.
REQ-029 At most one entry matches any PC; guaranteed by REQ-030.
REQ-030 upd_en with upd_pc matching a valid entry -> overwrite that entry's target only; replacement pointer unchanged.
REQ-031 upd_en with no match -> allocate lowest-index invalid entry; if none invalid, allocate entry at replacement pointer and advance pointer by 1 modulo BTB_DEPTH.
REQ-032 btb_inval=1 -> all valid bits cleared next edge, pointer to 0; same-cycle upd_en dropped.
REQ-033 Updates accepted during warm-up; only btb_hit/btb_target are gated by btb_ready.
REQ-034 Warm-up counter 8 bits, increments each cycle from 0, saturates at WARMUP; btb_ready = (count == WARMUP).
REQ-035 BTB and pipeline register independent: stall and flush do not block BTB updates or lookups.

Reset
REQ-036 cpurst_n=0 asynchronously clears: all de_* to 0, all entry valid/tag/target to 0, pointer 0, warm-up count 0, btb_ready 0.
REQ-037 Reset mid-operation discards all state; first post-reset cycle behaves as after power-on.

Verification
REQ-038 Release reset, fetch_pc=0x100, instr=0x00000013, valid=1 each cycle -> de_pc=0x100, de_instr=0x13, de_valid=1 one cycle later; btb_ready rises exactly 10 cycles after release.
REQ-039 stall=1 with flush=1 for 3 cycles, then stall=0, flush=1 -> de_* unchanged for 3 cycles, then de_instr=0, de_valid=0, de_pc=current fetch_pc.
REQ-040 After ready, update 0x200->0x400; lookup 0x200 same cycle -> hit=0; next cycle -> hit=1, target=0x400; update 0x200->0x500 -> target 0x500, no new entry used.
REQ-041 DEPTH=4: insert PCs 0x10,0x20,0x30,0x40, then 0x50 -> 0x10 evicted (lookup 0x10 misses), 0x60 evicts 0x20; others still hit.
REQ-042 btb_inval with upd_en same cycle -> all lookups miss next cycle, including upd_pc.
REQ-043 Update 0x300 during warm-up -> btb_hit=0 until btb_ready, then lookup 0x300 hits.
